// File: rtl/utopia_rx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : utopia_rx_arbiter
// Brief    : Round-robin merge of NUM_RX UTOPIA receive ports into a single
//            cell stream, with per-port cell counters and error flags.
// Revision : 1.0  initial release
// ============================================================================
module utopia_rx_arbiter #(
    parameter int NUM_RX     = 4,
    parameter int DATA_W     = 8,
    parameter int CELL_BYTES = 53,
    parameter int CNT_W      = 16,
    localparam int c_port_w  = (NUM_RX > 1) ? $clog2(NUM_RX) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RX-1:0]        rx_valid,
    input  logic [NUM_RX-1:0]        rx_soc,
    input  logic [NUM_RX*DATA_W-1:0] rx_data,
    output logic [NUM_RX-1:0]        rx_ready,
    input  logic [NUM_RX-1:0]        port_en,
    output logic                     out_valid,
    output logic                     out_soc,
    output logic [DATA_W-1:0]        out_data,
    output logic [c_port_w-1:0]      out_port,
    input  logic                     out_ready,
    input  logic [c_port_w-1:0]      cnt_sel,
    output logic [CNT_W-1:0]         cnt_value,
    input  logic                     cnt_clr,
    output logic [NUM_RX-1:0]        err,
    output logic                     busy
);

    localparam int c_bcnt_w = $clog2(CELL_BYTES);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FWD  = 1'b1
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [c_port_w-1:0]   r_grant, w_grant_nxt;
    logic [c_port_w-1:0]   r_last_grant, w_last_nxt;
    logic [c_port_w-1:0]   w_pick;
    logic [c_port_w:0]     w_tgt;
    logic [c_bcnt_w-1:0]   r_byte_cnt, w_bcnt_nxt;
    logic [CNT_W-1:0]      r_cnt [NUM_RX];
    logic [NUM_RX-1:0]     r_err, w_err_set, w_cnt_inc, w_cand;
    logic                  w_found, w_gvalid, w_gsoc, w_xfer, w_last_byte;
    logic [DATA_W-1:0]     w_gdata;

    assign w_cand      = rx_valid & rx_soc & port_en;
    assign w_last_byte = (r_byte_cnt == c_bcnt_w'(CELL_BYTES - 1));
    assign out_port    = r_grant;
    assign err         = r_err;

    // Granted-port mux and counter read port
    always_comb begin
        w_gvalid  = 1'b0;
        w_gsoc    = 1'b0;
        w_gdata   = '0;
        cnt_value = '0;
        for (int i = 0; i < NUM_RX; i++) begin
            if (r_grant == c_port_w'(i)) begin
                w_gvalid = rx_valid[i];
                w_gsoc   = rx_soc[i];
                w_gdata  = rx_data[i*DATA_W +: DATA_W];
            end
            if (cnt_sel == c_port_w'(i)) begin
                cnt_value = r_cnt[i];
            end
        end
    end

    // Round-robin search: distance 1 from last_grant has highest priority
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_tgt   = '0;
        for (int k = 1; k <= NUM_RX; k++) begin
            w_tgt = {1'b0, r_last_grant} + (c_port_w + 1)'(k);
            if (w_tgt >= (c_port_w + 1)'(NUM_RX)) begin
                w_tgt = w_tgt - (c_port_w + 1)'(NUM_RX);
            end
            for (int i = 0; i < NUM_RX; i++) begin
                if (!w_found && w_cand[i] && (w_tgt == (c_port_w + 1)'(i))) begin
                    w_found = 1'b1;
                    w_pick  = c_port_w'(i);
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last_grant;
        w_bcnt_nxt  = r_byte_cnt;
        w_err_set   = '0;
        w_cnt_inc   = '0;
        w_xfer      = 1'b0;
        rx_ready    = '0;
        out_valid   = 1'b0;
        out_soc     = 1'b0;
        out_data    = '0;
        busy        = 1'b0;
        if (rst) begin
            case (r_state)
                ST_IDLE: begin
                    // Stray non-SOC bytes are drained and flagged
                    for (int i = 0; i < NUM_RX; i++) begin
                        if (rx_valid[i] && !rx_soc[i]) begin
                            rx_ready[i]  = 1'b1;
                            w_err_set[i] = 1'b1;
                        end
                    end
                    if (w_found) begin
                        w_grant_nxt = w_pick;
                        w_last_nxt  = w_pick;
                        w_bcnt_nxt  = '0;
                        w_state_nxt = ST_FWD;
                    end
                end
                ST_FWD: begin
                    busy      = 1'b1;
                    out_valid = w_gvalid;
                    out_data  = w_gdata;
                    out_soc   = (r_byte_cnt == '0);
                    w_xfer    = w_gvalid & out_ready;
                    for (int i = 0; i < NUM_RX; i++) begin
                        if (r_grant == c_port_w'(i)) begin
                            rx_ready[i] = out_ready;
                            if (w_xfer && w_gsoc && (r_byte_cnt != '0)) begin
                                w_err_set[i] = 1'b1;
                            end
                            if (w_xfer && w_last_byte) begin
                                w_cnt_inc[i] = 1'b1;
                            end
                        end
                    end
                    if (w_xfer) begin
                        if (w_last_byte) begin
                            w_bcnt_nxt  = '0;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_bcnt_nxt  = r_byte_cnt + c_bcnt_w'(1);
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_byte_cnt   <= '0;
            r_last_grant <= c_port_w'(NUM_RX - 1);
            r_grant      <= '0;
            r_err        <= '0;
            for (int i = 0; i < NUM_RX; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_state      <= w_state_nxt;
            r_byte_cnt   <= w_bcnt_nxt;
            r_last_grant <= w_last_nxt;
            r_grant      <= w_grant_nxt;
            r_err        <= cnt_clr ? '0 : (r_err | w_err_set);
            for (int i = 0; i < NUM_RX; i++) begin
                if (cnt_clr) begin
                    r_cnt[i] <= '0;
                end else if (w_cnt_inc[i] && (r_cnt[i] != {CNT_W{1'b1}})) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_utopia_rx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_utopia_rx_arbiter
// Brief    : Directed self-checking bench for utopia_rx_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_utopia_rx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int CB = 53;
    localparam int CW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N-1:0]      rx_valid, rx_soc, rx_ready, port_en, err;
    logic [N*DW-1:0]   rx_data;
    logic              out_valid, out_soc, out_ready, cnt_clr, busy;
    logic [DW-1:0]     out_data;
    logic [1:0]        out_port, cnt_sel;
    logic [CW-1:0]     cnt_value;

    always #5 clk = ~clk;

    utopia_rx_arbiter #(
        .NUM_RX     (N),
        .DATA_W     (DW),
        .CELL_BYTES (CB),
        .CNT_W      (CW)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_soc    (rx_soc),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .port_en   (port_en),
        .out_valid (out_valid),
        .out_soc   (out_soc),
        .out_data  (out_data),
        .out_port  (out_port),
        .out_ready (out_ready),
        .cnt_sel   (cnt_sel),
        .cnt_value (cnt_value),
        .cnt_clr   (cnt_clr),
        .err       (err),
        .busy      (busy)
    );

    // Per-port cell sources: byte k of a cell is base+k, SOC on k==0 (and k==mid)
    bit          src_on   [N];
    bit          src_loop [N];
    int          src_idx  [N];
    int          src_mid  [N];
    logic [7:0]  src_base [N];

    logic [7:0]  lg_data [512];
    bit          lg_soc  [512];
    logic [1:0]  lg_port [512];
    int          nout, steps, busy_cyc, mirror_bad, rdy1_seen;
    bit          tog_mode;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            rx_valid[i]          = src_on[i];
            rx_soc[i]            = src_on[i] && (src_idx[i] == 0 || src_idx[i] == src_mid[i]);
            rx_data[i*DW +: DW]  = 8'(int'(src_base[i]) + src_idx[i]);
        end
    endtask

    task automatic step();
        logic [N-1:0] x;
        bit           ox;
        if (tog_mode) out_ready = ~out_ready;
        apply();
        #1;
        x  = rx_valid & rx_ready;
        ox = out_valid & out_ready;
        if (ox) begin
            if (nout < 512) begin
                lg_data[nout] = out_data;
                lg_soc[nout]  = out_soc;
                lg_port[nout] = out_port;
            end
            nout++;
        end
        if (busy && (rx_ready[out_port] !== out_ready)) mirror_bad++;
        if (rx_ready[1]) rdy1_seen++;
        if (busy) busy_cyc++;
        steps++;
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (x[i]) begin
                src_idx[i]++;
                if (src_idx[i] == CB) begin
                    src_idx[i] = 0;
                    if (!src_loop[i]) src_on[i] = 1'b0;
                end
            end
        end
        @(negedge clk);
        apply();
        #1;
    endtask

    task automatic run_outs(input int target, input int maxc);
        nout = 0; steps = 0; busy_cyc = 0; mirror_bad = 0; rdy1_seen = 0;
        while (nout < target && steps < maxc) step();
        check_eq("out_count", nout, target);
    endtask

    task automatic check_bytes(input string tag, input int start, input logic [7:0] base);
        int bad = 0;
        for (int j = 0; j < CB; j++) begin
            if (lg_data[start + j] !== 8'(int'(base) + j)) bad++;
        end
        check_eq(tag, bad, 0);
    endtask

    task automatic src_start(input int p, input logic [7:0] base, input int idx, input bit lp, input int mid);
        src_on[p] = 1'b1; src_base[p] = base; src_idx[p] = idx; src_loop[p] = lp; src_mid[p] = mid;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            src_on[i] = 1'b0; src_loop[i] = 1'b0; src_idx[i] = 0; src_mid[i] = -1; src_base[i] = '0;
        end
        out_ready = 1'b1; tog_mode = 1'b0; port_en = '1; cnt_clr = 1'b0; cnt_sel = '0;
        step(); step();
        rst = 1'b1;
        apply();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int socs;
        int others;
        // Reset with a live source: all handshake outputs must stay low
        do_reset();
        rst = 1'b0;
        src_start(2, 8'h00, 0, 1'b0, -1);
        step(); step();
        check_eq("rst_rx_ready", rx_ready, 4'b0000);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_err", err, 4'b0000);
        check_eq("rst_cnt", cnt_value, 2'd0);

        // Single cell on port 2
        do_reset();
        src_start(2, 8'h00, 0, 1'b0, -1);
        run_outs(CB, 200);
        check_eq("single_cycles", steps, 54);
        check_eq("single_port", lg_port[0], 2'd2);
        socs = 0;
        for (int j = 0; j < CB; j++) socs += int'(lg_soc[j]);
        check_eq("single_soc_cnt", socs, 1);
        check_eq("single_soc_first", lg_soc[0], 1'b1);
        check_bytes("single_bytes", 0, 8'h00);
        check_eq("single_busy_end", busy, 1'b0);
        cnt_sel = 2'd2; #1;
        check_eq("single_count2", cnt_value, 2'd1);

        // Fairness with all ports requesting continuously
        do_reset();
        for (int p = 0; p < N; p++) src_start(p, 8'(p * 64), 0, 1'b1, -1);
        run_outs(4 * CB, 300);
        check_eq("rr_cycles", steps, 216);
        check_eq("rr_order", {lg_port[0], lg_port[53], lg_port[106], lg_port[159]}, 8'b00_01_10_11);
        check_bytes("rr_bytes1", 53, 8'h40);
        check_bytes("rr_bytes3", 159, 8'hC0);
        step();
        check_eq("rr_wrap_port", out_port, 2'd0);
        check_eq("rr_wrap_busy", busy, 1'b1);
        for (int p = 0; p < N; p++) begin
            cnt_sel = 2'(p); #1;
            check_eq("rr_count", cnt_value, 2'd1);
        end
        check_eq("rr_err", err, 4'b0000);

        // Backpressure: out_ready toggles every cycle
        do_reset();
        out_ready = 1'b0; tog_mode = 1'b1;
        src_start(1, 8'h20, 0, 1'b0, -1);
        run_outs(CB, 300);
        tog_mode = 1'b0;
        check_eq("bp_cycles", steps, 107);
        check_bytes("bp_bytes", 0, 8'h20);
        check_eq("bp_mirror", mirror_bad, 0);
        check_eq("bp_busy_cyc", busy_cyc, 106);

        // Protocol errors and counter clear
        do_reset();
        src_start(1, 8'h00, 5, 1'b0, -1);
        apply(); #1;
        check_eq("drain_ready", rx_ready, 4'b0010);
        step();
        src_on[1] = 1'b0;
        apply(); #1;
        check_eq("drain_err", err, 4'b0010);
        src_start(0, 8'h50, 0, 1'b0, 10);
        run_outs(CB, 200);
        check_eq("midsoc_cycles", steps, 54);
        check_bytes("midsoc_bytes", 0, 8'h50);
        socs = 0;
        for (int j = 0; j < CB; j++) socs += int'(lg_soc[j]);
        check_eq("midsoc_out_soc", socs, 1);
        check_eq("midsoc_err", err, 4'b0011);
        check_eq("midsoc_busy_end", busy, 1'b0);
        cnt_sel = 2'd0; #1;
        check_eq("midsoc_count0", cnt_value, 2'd1);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        #1;
        check_eq("clr_err", err, 4'b0000);
        check_eq("clr_count0", cnt_value, 2'd0);

        // Saturation on port 3 while disabled port 1 keeps requesting
        do_reset();
        port_en = 4'b1101;
        src_start(3, 8'h10, 0, 1'b1, -1);
        src_start(1, 8'h20, 0, 1'b1, -1);
        run_outs(5 * CB, 400);
        check_eq("sat_cycles", steps, 270);
        others = 0;
        for (int j = 0; j < 5 * CB; j++) if (lg_port[j] != 2'd3) others++;
        check_eq("sat_only_port3", others, 0);
        check_eq("dis_ready1", rdy1_seen, 0);
        cnt_sel = 2'd3; #1;
        check_eq("sat_count3", cnt_value, 2'd3);
        cnt_sel = 2'd1; #1;
        check_eq("dis_count1", cnt_value, 2'd0);

        // Reset in the middle of a cell
        do_reset();
        src_start(3, 8'h30, 0, 1'b0, -1);
        run_outs(20, 100);
        check_eq("mid_port_pre", out_port, 2'd3);
        rst = 1'b0;
        apply(); #1;
        check_eq("mid_rst_valid", out_valid, 1'b0);
        check_eq("mid_rst_ready", rx_ready, 4'b0000);
        check_eq("mid_rst_busy", busy, 1'b0);
        check_eq("mid_rst_data", out_data, 8'h00);
        step();
        rst = 1'b1;
        src_start(0, 8'h80, 0, 1'b0, -1);
        src_start(2, 8'h90, 0, 1'b0, -1);
        apply(); #1;
        check_eq("mid_idle_busy", busy, 1'b0);
        check_eq("mid_idle_port", out_port, 2'd0);
        step();
        check_eq("mid_grant_port", out_port, 2'd0);
        check_eq("mid_grant_busy", busy, 1'b1);
        check_eq("mid_grant_soc", out_soc, 1'b1);
        check_eq("mid_grant_data", out_data, 8'h80);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/utopia_rx_arbiter.md
UTOPIA_RX_ARBITER -- requirements
Module: utopia_rx_arbiter

Interface
REQ-001 Parameter NUM_RX, default 4: number of receive ports, range 1..16.
REQ-002 Parameter DATA_W, default 8: cell byte width.
REQ-003 Parameter CELL_BYTES, default 53: bytes per cell, minimum 2.
REQ-004 Parameter CNT_W, default 16: width of each per-port cell counter.
REQ-005 Port clk  in  1  system clock; all state updates on the rising edge.
REQ-006 Port rst  in  1  reset, synchronous, active-low.
REQ-007 Port rx_valid  in  NUM_RX  per-port byte valid.
REQ-008 Port rx_soc  in  NUM_RX  per-port start-of-cell marker, qualified by rx_valid.
REQ-009 Port rx_data  in  NUM_RX*DATA_W  per-port byte; port i occupies bits [i*DATA_W +: DATA_W].
REQ-010 Port rx_ready  out  NUM_RX  per-port byte accept.
REQ-011 Port port_en  in  NUM_RX  per-port arbitration enable.
REQ-012 Port out_valid / out_soc / out_data  out  1/1/DATA_W  merged cell stream.
REQ-013 Port out_port  out  $clog2(NUM_RX) (min 1)  source port of the current cell.
REQ-014 Port out_ready  in  1  downstream accept.
REQ-015 Port cnt_sel  in  $clog2(NUM_RX) (min 1)  counter read select; cnt_value  out  CNT_W  combinational read of the selected counter (0 if cnt_sel >= NUM_RX).
REQ-016 Port cnt_clr  in  1  single-cycle clear of all counters and error flags.
REQ-017 Port err  out  NUM_RX  sticky per-port protocol-error flags.
REQ-018 Port busy  out  1  high while in state FWD.

Function
REQ-019 A byte transfers on port i when rx_valid[i] and rx_ready[i] are both high at a rising edge; downstream transfers when out_valid and out_ready are both high.
REQ-020 FSM states: IDLE and FWD only.
REQ-021 IDLE: port i is a candidate when rx_valid[i], rx_soc[i] and port_en[i] are all high.
REQ-022 IDLE grant: round-robin search starting at last_grant+1 (mod NUM_RX); the first candidate found is registered as grant, last_grant is set to it, and the next state is FWD with byte_cnt = 0.
REQ-023 No byte is forwarded in the grant cycle; minimum cell period is CELL_BYTES+1 cycles.
REQ-024 IDLE drain: for a port with rx_valid high and rx_soc low, rx_ready is high, the byte is discarded and err[i] is set.
REQ-025 IDLE: rx_ready is low for SOC bytes; out_valid is low.
REQ-026 FWD: out_valid = rx_valid[grant], out_data = rx_data[grant], rx_ready[grant] = out_ready, out_soc = (byte_cnt == 0), out_port = grant; these are combinational with zero latency.
REQ-027 FWD: rx_ready is low for all non-granted ports.
REQ-028 FWD: byte_cnt increments on each downstream transfer; the transfer at byte_cnt == CELL_BYTES-1 returns the FSM to IDLE and clears byte_cnt.
REQ-029 Cell completion increments the counter of port grant, saturating at 2^CNT_W-1.
REQ-030 FWD: rx_soc[grant] high on a transferred byte with byte_cnt != 0 sets err[grant]; the byte is forwarded unchanged and the cell is not truncated.
REQ-031 Deasserting port_en[grant] mid-cell has no effect on the current cell; it affects only later grants.
REQ-032 out_ready low or rx_valid[grant] low stalls the cell with no state change (no timeout).
REQ-033 cnt_clr zeroes all counters and err bits; when it coincides with an increment or error set, the clear wins.
REQ-034 out_port holds the last grant while in IDLE.

Reset
REQ-035 While rst is low at a rising edge: state = IDLE, byte_cnt = 0, last_grant = NUM_RX-1 (so port 0 wins first), grant = 0, all counters = 0, err = 0.
REQ-036 While rst is low: out_valid, out_soc, rx_ready and busy are forced to 0, and out_data is 0.
REQ-037 Reset asserted mid-cell abandons the cell; after release the next byte must be an SOC to be forwarded.

Verification
REQ-038 Single cell: port 2 sends 53 bytes 0x00..0x34 with SOC on the first byte, out_ready = 1 -> out_port = 2, out_soc only on 0x00, 53 out transfers, count[2] = 1, total 54 cycles.
REQ-039 Fairness: all four ports hold SOC continuously -> grant order is 0,1,2,3,0; each count = 1 after 4 cells.
REQ-040 Backpressure: out_ready toggles 1/0 during a cell -> byte order is preserved, rx_ready[grant] mirrors out_ready, busy spans the whole cell.
REQ-041 Errors: a non-SOC byte on port 1 in IDLE -> drained, err[1] = 1; SOC mid-cell on port 0 -> err[0] = 1 and the cell still has 53 bytes; then cnt_clr -> err = 0 and counts = 0.
REQ-042 Saturation and disable: with CNT_W = 2, 5 cells on port 3 -> count[3] = 3; with port_en[1] = 0, port 1 SOC is never granted and rx_ready[1] stays 0.
REQ-043 Reset mid-cell at byte 20 -> outputs 0 during reset, IDLE after release, and port 0 is granted first.
